// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: turns 10 kHz divider ticks into a 20 ms frame with a clamped pulse width.
// Optional macro SERVO_RAMP_EN limits the pulse-width change per frame to RAMP_STEP ticks.
module servo_pwm_gen #(
    parameter int unsigned PERIOD_TICKS = 200,
    parameter int unsigned MIN_TICKS    = 5,
    parameter int unsigned MAX_TICKS    = 25,
    parameter int unsigned POS_W        = 8,
    parameter int unsigned RAMP_STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_sq,
    input  logic             enable,
    input  logic [POS_W-1:0] pos_in,
    input  logic             pos_load,
    output logic             pwm_out,
    output logic             frame_start,
    output logic [POS_W-1:0] cur_pos,
    output logic             pending
);

    localparam int unsigned      CNT_W    = $clog2(PERIOD_TICKS);
    localparam logic [POS_W-1:0] MIN_POS  = POS_W'(MIN_TICKS);
    localparam logic [POS_W-1:0] MAX_POS  = POS_W'(MAX_TICKS);
    localparam logic [POS_W-1:0] MID_POS  = POS_W'((MIN_TICKS + MAX_TICKS) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_TICKS - 1);

`ifdef SERVO_RAMP_EN
    localparam int unsigned STEP_LIM = RAMP_STEP;
`else
    // Any step at least as wide as the clamp range lands on the shadow value in one frame.
    localparam int unsigned STEP_LIM = (RAMP_STEP > MAX_TICKS) ? RAMP_STEP : MAX_TICKS;
`endif

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [POS_W-1:0] shadow;
    logic             s0, s1, s2;

    logic             tick;
    logic             at_boundary;
    logic [CNT_W-1:0] cnt_next;
    logic [POS_W-1:0] pos_clamped;
    logic [POS_W-1:0] next_pos;
    int unsigned      cur_i, sh_i;

    assign tick        = s1 & ~s2;
    assign cnt_next    = cnt + CNT_W'(1);
    assign at_boundary = tick && (state == StIdle || (state == StLow && cnt == LAST_CNT));

    always_comb begin
        pos_clamped = pos_in;
        if (pos_in < MIN_POS) begin
            pos_clamped = MIN_POS;
        end else if (pos_in > MAX_POS) begin
            pos_clamped = MAX_POS;
        end
    end

    always_comb begin
        cur_i    = 32'(cur_pos);
        sh_i     = 32'(shadow);
        next_pos = shadow;
        if (cur_i + STEP_LIM < sh_i) begin
            next_pos = cur_pos + POS_W'(STEP_LIM);
        end else if (sh_i + STEP_LIM < cur_i) begin
            next_pos = cur_pos - POS_W'(STEP_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s0          <= 1'b0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= StIdle;
            cnt         <= '0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            pending     <= 1'b0;
            shadow      <= MID_POS;
            cur_pos     <= MID_POS;
        end else begin
            s0          <= tick_sq;
            s1          <= s0;
            s2          <= s1;
            frame_start <= 1'b0;

            if (at_boundary) begin
                cnt <= '0;
                if (enable) begin
                    frame_start <= 1'b1;
                    cur_pos     <= next_pos;
                    pwm_out     <= 1'b1;
                    state       <= StHigh;
                    if (next_pos == shadow) begin
                        pending <= 1'b0;
                    end
                end else begin
                    pwm_out <= 1'b0;
                    state   <= StIdle;
                end
            end else if (tick) begin
                case (state)
                    StHigh: begin
                        cnt <= cnt_next;
                        if (32'(cnt_next) == 32'(cur_pos)) begin
                            pwm_out <= 1'b0;
                            state   <= StLow;
                        end
                    end
                    StLow:   cnt <= cnt_next;
                    default: cnt <= '0;
                endcase
            end

            // A load on a boundary cycle stays pending: the boundary above used the old shadow.
            if (pos_load) begin
                shadow  <= pos_clamped;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: 20-clk tick_sq period, so one tick = 20 clk and one frame = 4000 clk.
module tb_servo_pwm_gen;

    localparam int LIMIT = 5000;

    logic       clk;
    logic       reset;
    logic       tick_sq;
    logic       enable;
    logic [7:0] pos_in;
    logic       pos_load;
    logic       pwm_out;
    logic       frame_start;
    logic [7:0] cur_pos;
    logic       pending;

    int checks = 0;
    int errors = 0;

    servo_pwm_gen dut (
        .clk         (clk),
        .reset       (reset),
        .tick_sq     (tick_sq),
        .enable      (enable),
        .pos_in      (pos_in),
        .pos_load    (pos_load),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .cur_pos     (cur_pos),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial tick_sq = 1'b0;
    always #100 tick_sq = ~tick_sq;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int v);
        pos_in   = 8'(v);
        pos_load = 1'b1;
        @(negedge clk);
        pos_load = 1'b0;
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        while (!frame_start && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called on the negedge where frame_start is high; returns at the next frame_start or LIMIT.
    task automatic measure(input int drop, output int hi, output int per, output int cp,
                           output int pd);
        cp  = int'(cur_pos);
        pd  = int'(pending);
        hi  = 0;
        per = 0;
        do begin
            hi += int'(pwm_out);
            @(negedge clk);
            per++;
            if (drop > 0 && per == drop) enable = 1'b0;
        end while (!frame_start && per < LIMIT);
    endtask

    initial begin
        int n, hi, per, cp, pd, activity;

        reset    = 1'b0;
        enable   = 1'b0;
        pos_load = 1'b0;
        pos_in   = 8'd0;
        repeat (5) @(negedge clk);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_cur_pos", int'(cur_pos), 15);
        check("rst_pending", int'(pending), 0);

        reset    = 1'b1;
        activity = 0;
        repeat (12000) begin
            @(negedge clk);
            if (pwm_out || frame_start) activity++;
        end
        check("idle_quiet", activity, 0);

        // Nominal frame
        load(15);
        check("load_pending", int'(pending), 1);
        enable = 1'b1;
        wait_fs(n);
        check("first_frame_seen", int'(n < LIMIT), 1);
        measure(0, hi, per, cp, pd);
        check("nom_high", hi, 300);
        check("nom_period", per, 4000);
        check("nom_cur_pos", cp, 15);
        check("nom_pending", pd, 0);

        // Clamps
        load(0);
        measure(0, hi, per, cp, pd);
        measure(0, hi, per, cp, pd);
        check("clamp_lo_high", hi, 100);
        check("clamp_lo_cur_pos", cp, 5);
        load(200);
        measure(0, hi, per, cp, pd);
        measure(0, hi, per, cp, pd);
        check("clamp_hi_high", hi, 500);
        check("clamp_hi_cur_pos", cp, 25);

        // Load on the exact boundary edge, 4000 clk after the current frame_start
        repeat (3999) @(negedge clk);
        pos_in   = 8'd20;
        pos_load = 1'b1;
        @(negedge clk);
        pos_load = 1'b0;
        check("bnd_frame_start", int'(frame_start), 1);
        check("bnd_cur_pos", int'(cur_pos), 25);
        check("bnd_pending", int'(pending), 1);
        measure(0, hi, per, cp, pd);
        check("bnd_old_high", hi, 500);
        measure(0, hi, per, cp, pd);
        check("bnd_new_cur_pos", cp, 20);
        check("bnd_new_pending", pd, 0);
        check("bnd_new_high", hi, 400);

        // Disable at tick 3 of a 15-tick pulse
        load(15);
        measure(0, hi, per, cp, pd);
        measure(60, hi, per, cp, pd);
        check("dis_cur_pos", cp, 15);
        check("dis_high", hi, 300);
        check("dis_no_frame_start", per, LIMIT);
        activity = 0;
        repeat (4000) begin
            @(negedge clk);
            if (pwm_out || frame_start) activity++;
        end
        check("dis_quiet", activity, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
